// File: rtl/uart_row_pkg.sv
// Shared codes and enums for the row-transfer UART protocol, used by both the
// sender and the receiver controller.
package uart_row_pkg;

  localparam logic [7:0] UR_END_WORD = 8'hDD;
  localparam logic [7:0] UR_ACK_ROW  = 8'hCC;
  localparam logic [7:0] UR_ACK_DATA = 8'hAA;
  localparam logic [7:0] UR_ACK_OK   = 8'hBC;
  localparam logic [7:0] UR_ACK_NACK = 8'h11;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_NACK    = 2'd1,
    ST_BAD_ACK = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    PH_START,
    PH_ROW,
    PH_DATA,
    PH_END
  } phase_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_LOAD,
    S_TX_WAIT,
    S_ACK_WAIT,
    S_FINISH
  } state_e;

endpackage

// File: rtl/uart_row_sender_if.sv
// Byte-level link between the row sender and its UART transmitter/receiver pair.
interface uart_row_sender_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_done;

  modport master (output tx_data, tx_start, input tx_busy, rx_data, rx_done);
  modport slave  (input tx_data, tx_start, output tx_busy, rx_data, rx_done);
endinterface

// File: rtl/uart_row_timeout.sv
// Wait-state watchdog: counts cycles while run is high, clears whenever run drops,
// and flags expiry on the TIMEOUT_CYCLES-th cycle of a continuous run.
module uart_row_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = run && (count == LAST);
endmodule

// File: rtl/uart_row_sender.sv
// Initiator of the row-transfer UART protocol: sends start, row, pixel bytes and
// END_WORD one at a time, checking each acknowledgement the responder returns.
module uart_row_sender
  import uart_row_pkg::*;
#(
  parameter int         DATA_BYTES     = 240,
  parameter logic [7:0] END_WORD       = UR_END_WORD,
  parameter logic [7:0] ACK_ROW        = UR_ACK_ROW,
  parameter logic [7:0] ACK_DATA       = UR_ACK_DATA,
  parameter logic [7:0] ACK_OK         = UR_ACK_OK,
  parameter logic [7:0] ACK_NACK       = UR_ACK_NACK,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8:0]              row,
  input  logic [8*DATA_BYTES-1:0] row_data,
  output logic                    ready,
  output logic                    done,
  output status_e                 status,
  uart_row_sender_if.master       link
);
  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  state_e                  state;
  phase_e                  phase;
  logic [IDX_W-1:0]        idx;
  logic                    busy_seen;
  logic [8:0]              row_q;
  logic [8*DATA_BYTES-1:0] row_data_q;
  logic [7:0]              phase_byte;
  logic [7:0]              ack_expect;
  logic                    accept;
  logic                    tx_exit;
  logic                    tmo_run;
  logic                    tmo_expired;

  assign accept  = (state == S_IDLE) && start && ready;
  assign tx_exit = (state == S_TX_WAIT) && busy_seen && !link.tx_busy;
  // Leaving TX_WAIT drops run for a cycle so the next wait state starts from zero.
  assign tmo_run = (state == S_ACK_WAIT) || ((state == S_TX_WAIT) && !tx_exit);

  uart_row_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .run     (tmo_run),
    .expired (tmo_expired)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    phase_byte = END_WORD;
    ack_expect = ACK_DATA;
    unique case (phase)
      PH_START: begin
        phase_byte = {7'b0, row_q[8]};
        ack_expect = ACK_ROW;
      end
      PH_ROW: begin
        phase_byte = row_q[7:0];
        ack_expect = ACK_ROW;
      end
      PH_DATA: phase_byte = row_data_q[8*int'(idx) +: 8];
      PH_END:  phase_byte = END_WORD;
    endcase
  end

  // NOTE: the frame payload registers have no reset; they are only read after an accept loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      row_q      <= row;
      row_data_q <= row_data;
    end
  end

  // NOTE: non-blocking assignments throughout, so the pulse defaults below are overridden by later lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      phase        <= PH_START;
      idx          <= '0;
      busy_seen    <= 1'b0;
      ready        <= 1'b1;
      done         <= 1'b0;
      status       <= ST_OK;
      link.tx_data  <= 8'h00;
      link.tx_start <= 1'b0;
    end else begin
      link.tx_start <= 1'b0;
      done          <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            phase  <= PH_START;
            idx    <= '0;
            status <= ST_OK;
            ready  <= 1'b0;
            state  <= S_TX_LOAD;
          end
        end
        S_TX_LOAD: begin
          if (!link.tx_busy) begin
            link.tx_data  <= phase_byte;
            link.tx_start <= 1'b1;
            busy_seen     <= 1'b0;
            state         <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (tx_exit) begin
            // The last pixel byte is not acknowledged; go straight on to END_WORD.
            if (phase == PH_DATA && idx == LAST_IDX) begin
              phase <= PH_END;
              state <= S_TX_LOAD;
            end else begin
              state <= S_ACK_WAIT;
            end
          end else if (tmo_expired) begin
            status <= ST_TIMEOUT;
            done   <= 1'b1;
            state  <= S_FINISH;
          end else if (link.tx_busy) begin
            busy_seen <= 1'b1;
          end
        end
        S_ACK_WAIT: begin
          if (link.rx_done) begin
            if (phase == PH_END) begin
              if (link.rx_data == ACK_OK)        status <= ST_OK;
              else if (link.rx_data == ACK_NACK) status <= ST_NACK;
              else                               status <= ST_BAD_ACK;
              done  <= 1'b1;
              state <= S_FINISH;
            end else if (link.rx_data != ack_expect) begin
              status <= ST_BAD_ACK;
              done   <= 1'b1;
              state  <= S_FINISH;
            end else begin
              state <= S_TX_LOAD;
              if (phase == PH_START) begin
                phase <= PH_ROW;
              end else if (phase == PH_ROW) begin
                phase <= PH_DATA;
                idx   <= '0;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end else if (tmo_expired) begin
            status <= ST_TIMEOUT;
            done   <= 1'b1;
            state  <= S_FINISH;
          end
        end
        S_FINISH: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_row_sender.sv
// Self-checking bench for uart_row_sender: a cycle-stepped transmitter/responder
// model drives the link, and a byte-sequence model checks every transmitted byte.
module tb_uart_row_sender;
  import uart_row_pkg::*;

  localparam int DATA_BYTES     = 240;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int FRAME_BYTES    = DATA_BYTES + 3;
  localparam int FRAME_BUDGET   = 8000;
  localparam int NUM_VECS       = 9;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [8:0]              row;
  logic [8*DATA_BYTES-1:0] row_data;
  logic                    ready;
  logic                    done;
  logic [1:0]              status;

  uart_row_sender_if link ();

  uart_row_sender #(
    .DATA_BYTES     (DATA_BYTES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .row      (row),
    .row_data (row_data),
    .ready    (ready),
    .done     (done),
    .status   (status),
    .link     (link)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         pattern;     // 0: ramp data with given row, 1: random row and data
    logic [8:0] row;
    logic [7:0] end_resp;
    int         bad_pos;     // frame byte answered with a wrong ack (-1 none)
    int         silent_pos;  // frame byte never acknowledged (-1 none)
    int         stuck_pos;   // frame byte whose busy never drops (-1 none)
    bit         extra;       // responder sends a residual byte after the status byte
    bit         stray;       // stray rx_done while the DUT is still transmitting
    int         exp_status;
    int         exp_bytes;
  } vec_t;

  vec_t vecs [NUM_VECS];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Environment state (transmitter + responder model)
  int         busy_left;
  bit         stuck;
  bit         ack_pending;
  int         ack_delay;
  logic [7:0] ack_byte;
  bit         ack_is_end;
  bit         extra_pending;
  int         tx_count;
  int         cur_pos;
  int         last_fall_cyc;
  int         last_start_cyc;
  logic [7:0] tx_log [$];
  int         cfg_bad, cfg_silent, cfg_stuck;
  logic [7:0] cfg_end;
  bit         cfg_extra, cfg_stray;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [7:0] model_byte(input int pos, input logic [8:0] r,
                                            input logic [8*DATA_BYTES-1:0] d);
    if (pos == 0) return {7'b0, r[8]};
    if (pos == 1) return r[7:0];
    if (pos <= DATA_BYTES + 1) return d[8*(pos-2) +: 8];
    return UR_END_WORD;
  endfunction

  task automatic respond(input int pos);
    if (pos == cfg_silent || pos == FRAME_BYTES - 2) return;
    ack_pending = 1'b1;
    ack_delay   = int'($urandom_range(1, 4));
    ack_is_end  = (pos == FRAME_BYTES - 1);
    if (pos == cfg_bad)                ack_byte = 8'h55;
    else if (pos < 2)                  ack_byte = UR_ACK_ROW;
    else if (pos == FRAME_BYTES - 1)   ack_byte = cfg_end;
    else                               ack_byte = UR_ACK_DATA;
  endtask

  task automatic env_step();
    link.rx_done = 1'b0;
    if (ack_pending) begin
      if (ack_delay <= 1) begin
        link.rx_done = 1'b1;
        link.rx_data = ack_byte;
        ack_pending  = 1'b0;
        if (ack_is_end && cfg_extra) extra_pending = 1'b1;
      end else begin
        ack_delay--;
      end
    end else if (extra_pending) begin
      link.rx_done  = 1'b1;
      link.rx_data  = 8'h77;
      extra_pending = 1'b0;
    end
    if (busy_left > 0 && !stuck) begin
      busy_left--;
      if (busy_left == 0) begin
        link.tx_busy  = 1'b0;
        last_fall_cyc = cyc;
        respond(cur_pos);
      end
    end
    if (link.tx_start === 1'b1) begin
      tx_log.push_back(link.tx_data);
      cur_pos        = tx_count;
      tx_count++;
      last_start_cyc = cyc;
      link.tx_busy   = 1'b1;
      stuck          = (cur_pos == cfg_stuck);
      busy_left      = int'($urandom_range(1, 3));
      if (cfg_stray && cur_pos == 2) begin
        link.rx_done = 1'b1;
        link.rx_data = 8'h55;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    env_step();
  endtask

  task automatic env_clear();
    busy_left     = 0;
    stuck         = 1'b0;
    ack_pending   = 1'b0;
    extra_pending = 1'b0;
    tx_count      = 0;
    cur_pos       = 0;
    tx_log.delete();
    link.tx_busy  = 1'b0;
    link.rx_done  = 1'b0;
    link.rx_data  = 8'h00;
  endtask

  task automatic env_config(input vec_t v);
    env_clear();
    cfg_bad    = v.bad_pos;
    cfg_silent = v.silent_pos;
    cfg_stuck  = v.stuck_pos;
    cfg_end    = v.end_resp;
    cfg_extra  = v.extra;
    cfg_stray  = v.stray;
  endtask

  task automatic make_payload(input vec_t v, output logic [8:0] r, output logic [8*DATA_BYTES-1:0] d);
    r = (v.pattern == 0) ? v.row : 9'($urandom);
    for (int k = 0; k < DATA_BYTES; k++)
      d[8*k +: 8] = (v.pattern == 0) ? 8'(k) : 8'($urandom);
  endtask

  task automatic run_frame(input vec_t v);
    logic [8:0]              frow;
    logic [8*DATA_BYTES-1:0] fdata;
    bit                      got_done;
    int                      done_cyc;
    logic [1:0]              got_status;
    int                      mism;
    int                      saved;
    int                      pulses;

    env_config(v);
    make_payload(v, frow, fdata);
    check($sformatf("%s.ready_idle", v.name), 32'(ready), 32'd1);
    row      = frow;
    row_data = fdata;
    start    = 1'b1;
    tick();
    check($sformatf("%s.ready_after_accept", v.name), 32'(ready), 32'd0);
    // Post-accept input changes and repeated start must have no effect.
    row      = ~frow;
    row_data = ~fdata;
    got_done   = 1'b0;
    done_cyc   = 0;
    got_status = 2'd0;
    for (int c = 0; c < FRAME_BUDGET && !got_done; c++) begin
      if (c == 2) start = 1'b0;
      tick();
      if (done === 1'b1) begin
        got_done   = 1'b1;
        done_cyc   = cyc;
        got_status = status;
      end
    end
    start = 1'b0;
    check($sformatf("%s.done_seen", v.name), 32'(got_done), 32'd1);
    check($sformatf("%s.status", v.name), 32'(got_status), 32'(v.exp_status));
    check($sformatf("%s.tx_count", v.name), 32'(tx_count), 32'(v.exp_bytes));
    mism = 0;
    for (int i = 0; i < tx_log.size(); i++)
      if (tx_log[i] !== model_byte(i, frow, fdata)) mism++;
    check($sformatf("%s.tx_bytes_mismatches", v.name), 32'(mism), 32'd0);
    if (v.silent_pos >= 0)
      check($sformatf("%s.ack_timeout_latency", v.name), 32'(done_cyc - (last_fall_cyc + 1)),
            32'(TIMEOUT_CYCLES));
    if (v.stuck_pos >= 0)
      check($sformatf("%s.busy_timeout_latency", v.name), 32'(done_cyc - last_start_cyc),
            32'(TIMEOUT_CYCLES));
    tick();
    check($sformatf("%s.ready_after_done", v.name), 32'(ready), 32'd1);
    check($sformatf("%s.done_one_cycle", v.name), 32'(done), 32'd0);
    saved  = tx_count;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check($sformatf("%s.quiet_tx", v.name), 32'(tx_count), 32'(saved));
    check($sformatf("%s.quiet_done", v.name), 32'(pulses), 32'd0);
    check($sformatf("%s.status_hold", v.name), 32'(status), 32'(v.exp_status));
  endtask

  initial begin
    logic [8:0]              frow;
    logic [8*DATA_BYTES-1:0] fdata;
    bit                      hit;
    int                      pulses;

    //        name              pat row      end    bad  sil  stk ext str st  bytes
    vecs[0] = '{"normal",         0, 9'h12A, 8'hBC,  -1,  -1,  -1, 0, 0, 0, 243};
    vecs[1] = '{"end_nack",       0, 9'h12A, 8'h11,  -1,  -1,  -1, 1, 0, 1, 243};
    vecs[2] = '{"bad_data5",      0, 9'h12A, 8'hBC,   7,  -1,  -1, 0, 0, 2,   8};
    vecs[3] = '{"timeout_ack",    0, 9'h12A, 8'hBC,  -1,   1,  -1, 0, 0, 3,   2};
    vecs[4] = '{"timeout_busy",   0, 9'h0F3, 8'hBC,  -1,  -1,   3, 0, 0, 3,   4};
    vecs[5] = '{"rand_ok_stray",  1, 9'h000, 8'hBC,  -1,  -1,  -1, 0, 1, 0, 243};
    vecs[6] = '{"rand_end_other", 1, 9'h000, 8'h42,  -1,  -1,  -1, 1, 0, 2, 243};
    vecs[7] = '{"bad_start",      1, 9'h000, 8'hBC,   0,  -1,  -1, 0, 0, 2,   1};
    vecs[8] = '{"bad_last_acked", 1, 9'h000, 8'hBC, 240,  -1,  -1, 0, 0, 2, 241};

    rst      = 1'b1;
    start    = 1'b0;
    row      = 9'h000;
    row_data = '0;
    env_config(vecs[0]);
    repeat (3) tick();
    check("reset.ready", 32'(ready), 32'd1);
    check("reset.done", 32'(done), 32'd0);
    check("reset.status", 32'(status), 32'd0);
    check("reset.tx_start", 32'(link.tx_start), 32'd0);
    check("reset.tx_data", 32'(link.tx_data), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NUM_VECS; i++) run_frame(vecs[i]);

    // Synchronous reset while data byte 100 is in flight.
    env_config(vecs[0]);
    make_payload(vecs[0], frow, fdata);
    row      = frow;
    row_data = fdata;
    start    = 1'b1;
    tick();
    start = 1'b0;
    hit   = 1'b0;
    for (int c = 0; c < FRAME_BUDGET && !hit; c++) begin
      tick();
      if (tx_count == 103) hit = 1'b1;
    end
    check("mid_reset.reached_k100", 32'(hit), 32'd1);
    rst = 1'b1;
    env_clear();
    tick();
    check("mid_reset.ready", 32'(ready), 32'd1);
    check("mid_reset.done", 32'(done), 32'd0);
    check("mid_reset.tx_start", 32'(link.tx_start), 32'd0);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("mid_reset.no_done", 32'(pulses), 32'd0);
    check("mid_reset.no_tx", 32'(tx_count), 32'd0);
    run_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_row_sender.md
Name: uart_row_sender

Overview:
- Initiator side of the row-transfer UART protocol; the image-row receiver controller is the responder.
- Sends one frame: start byte, row byte, DATA_BYTES pixel bytes, END_WORD. Checks every acknowledgement byte the responder returns.
- Drives an external uart_transmiter through a byte start/busy handshake. Takes acknowledgement bytes from an external uart_receiver through a byte/done strobe.
- Used by the test-pattern host model and by the loopback board build.

Parameters:
- DATA_BYTES, 240, pixel bytes per frame.
- END_WORD, 8'hDD, frame terminator.
- ACK_ROW, 8'hCC, acknowledgement after the start byte and after the row byte.
- ACK_DATA, 8'hAA, acknowledgement after data bytes 0..DATA_BYTES-2.
- ACK_OK, 8'hBC, end status: success.
- ACK_NACK, 8'h11, end status: incomplete.
- TIMEOUT_CYCLES, 100000, maximum cycles in TX_WAIT or ACK_WAIT.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, frame request; sampled only while ready=1.
- row, in, 9, row number.
- row_data, in, 8*DATA_BYTES, pixel bytes; byte k = row_data[8k+7:8k].
- ready, out, 1, idle and able to accept start.
- done, out, 1, one-cycle pulse at frame end.
- status, out, 2, frame result: 0 OK, 1 NACK, 2 BAD_ACK, 3 TIMEOUT.
- tx_data, out, 8, byte to the transmitter.
- tx_start, out, 1, one-cycle transmit strobe.
- tx_busy, in, 1, transmitter busy.
- rx_data, in, 8, received byte.
- rx_done, in, 1, one-cycle received-byte strobe.

Behaviour:
- Reset: state IDLE, ready=1, done=0, status=0, tx_data=0, tx_start=0, byte index=0, timeout counter=0. Reset mid-frame aborts at once: no done pulse, no further tx_start.
- Accept: start && ready latches row and row_data into internal registers. ready=0 from the next cycle. Changes on the inputs after acceptance have no effect. start while ready=0 is ignored.
- States and transitions:
  - IDLE → TX_LOAD on accept.
  - TX_LOAD: waits for tx_busy=0, then pulses tx_start for 1 cycle with tx_data valid in the same cycle → TX_WAIT.
  - TX_WAIT: waits for tx_busy observed 1 then 0. Then goes to ACK_WAIT, or to TX_LOAD when no acknowledgement is expected.
  - ACK_WAIT: on rx_done, compares rx_data with the expected byte.
  - FINISH: done=1 for 1 cycle, status driven → IDLE. ready=1 from the cycle after done.
- Phase sequence and tx_data:
  - START: {7'b0,row[8]}, expects ACK_ROW.
  - ROW: row[7:0], expects ACK_ROW.
  - DATA k=0..DATA_BYTES-2: byte k, expects ACK_DATA.
  - DATA k=DATA_BYTES-1: last byte, no acknowledgement → TX_LOAD for END.
  - END: END_WORD. rx_data==ACK_OK gives status 0; rx_data==ACK_NACK gives status 1; any other byte gives status 2.
- Mismatched acknowledgement in any phase: → FINISH with status 2. No further bytes are sent.
- Timeout: the counter clears on entry to TX_WAIT and to ACK_WAIT and increments every cycle in those states. Reaching TIMEOUT_CYCLES-1 without the exit condition → FINISH with status 3. A frame with no stalls never times out.
- rx_done outside ACK_WAIT (IDLE, TX_LOAD, TX_WAIT, FINISH) is discarded. Any byte the responder sends after a status byte is also discarded.
- The byte index counts 0..DATA_BYTES-1 with width $clog2(DATA_BYTES). It never wraps within a frame and clears on accept.
- status holds from the done pulse until the next accept.
- Bytes per complete frame: DATA_BYTES+3, i.e. 243 tx_start pulses.

Decomposition:
- Package uart_row_pkg holds the following, shared with the receiver controller:
  - the acknowledgement and END codes;
  - the status enum (ST_OK, ST_NACK, ST_BAD_ACK, ST_TIMEOUT);
  - the phase enum (PH_START, PH_ROW, PH_DATA, PH_END);
  - the FSM state enum.
- One sub-module, uart_row_timeout: a clearable counter with an expiry flag, sized by TIMEOUT_CYCLES. The FSM and byte multiplexer stay in uart_row_sender.

Test Plan:
- Normal frame: row=9'h12A, byte k=k[7:0], responder model returns the correct acknowledgements → tx bytes 0x01, 0x2A, 0x00..0xEF, 0xDD (243 strobes); done with status 0; ready=1 on the following cycle.
- End NACK: the same frame with the responder answering 0x11 to END_WORD → done, status 1; the trailing residual byte from the responder is ignored.
- Bad acknowledgement: responder returns 0x55 after data byte 5 → done, status 2; no tx_start after byte 5.
- Timeout: TIMEOUT_CYCLES=64, no acknowledgement after the row byte → done exactly 64 cycles after ACK_WAIT entry, status 3. A second run with tx_busy stuck high in TX_WAIT also ends with status 3.
- Robustness:
  - start pulses and an rx_done strobe in IDLE while ready=0 → ignored; row_data changes mid-frame → transmitted bytes unchanged.
  - rst asserted during DATA k=100 → ready=1 the next cycle, no done pulse; a new frame then completes with status 0.
